// File: rtl/pid_pkg.sv
// Shared types and width helpers for the multi-channel incremental PID controller.
package pid_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ERR   = 3'd1,
    S_MP    = 3'd2,
    S_MI    = 3'd3,
    S_MD    = 3'd4,
    S_CLAMP = 3'd5
  } state_t;

  // Error e = setpoint - sample needs one extra sign bit.
  function automatic int err_w(input int dw);
    return dw + 1;
  endfunction

  // Sums/differences of two errors need one more bit again.
  function automatic int diff_w(input int dw);
    return dw + 2;
  endfunction

  // Zero-extended gain (gw+1 signed) times a diff_w operand.
  function automatic int prod_w(input int gw, input int dw);
    return gw + dw + 3;
  endfunction

  // Accumulator of three products; one guard bit is enough.
  function automatic int acc_w(input int gw, input int dw);
    return gw + dw + 4;
  endfunction

  // Saturate a signed value into [lo, hi].
  function automatic logic signed [63:0] clamp_s64(input logic signed [63:0] u,
                                                   input logic signed [63:0] lo,
                                                   input logic signed [63:0] hi);
    if (u < lo) return lo;
    else if (u > hi) return hi;
    else return u;
  endfunction

endpackage

// File: rtl/pid_chan_mem.sv
// Per-channel state: setpoint, previous error and previous (clamped) output.
module pid_chan_mem import pid_pkg::*; #(
  parameter int DW       = 16,
  parameter int NCH      = 4,
  parameter int CW       = 2,
  parameter int SP_RESET = 54321
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic [CW-1:0]                 rd_ch,
  output logic [DW-1:0]                 rd_sp,
  output logic signed [err_w(DW)-1:0]   rd_ep,
  output logic [DW-1:0]                 rd_yp,
  input  logic                          hist_we,
  input  logic [CW-1:0]                 hist_ch,
  input  logic signed [err_w(DW)-1:0]   hist_ep,
  input  logic [DW-1:0]                 hist_yp,
  input  logic                          sp_we,
  input  logic [CW-1:0]                 sp_ch,
  input  logic [DW-1:0]                 sp_data
);

  localparam int EW = err_w(DW);

  logic [DW-1:0]        sp_q [NCH];
  logic [DW-1:0]        sp_d [NCH];
  logic signed [EW-1:0] ep_q [NCH];
  logic signed [EW-1:0] ep_d [NCH];
  logic [DW-1:0]        yp_q [NCH];
  logic [DW-1:0]        yp_d [NCH];

  assign rd_sp = sp_q[rd_ch];
  assign rd_ep = ep_q[rd_ch];
  assign rd_yp = yp_q[rd_ch];

  // Next entry values: clear wipes histories, then history and setpoint writes apply.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      sp_d[i] = sp_q[i];
      ep_d[i] = ep_q[i];
      yp_d[i] = yp_q[i];
    end
    if (clr) begin
      for (int i = 0; i < NCH; i++) begin
        ep_d[i] = '0;
        yp_d[i] = '0;
      end
    end
    if (hist_we) begin
      ep_d[hist_ch] = hist_ep;
      yp_d[hist_ch] = hist_yp;
    end
    if (sp_we) sp_d[sp_ch] = sp_data;
  end

  // Entry registers; reset restores default setpoints and empty histories.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        sp_q[i] <= DW'(SP_RESET);
        ep_q[i] <= '0;
        yp_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        sp_q[i] <= sp_d[i];
        ep_q[i] <= ep_d[i];
        yp_q[i] <= yp_d[i];
      end
    end
  end

endmodule

// File: rtl/pid_mc.sv
// Multi-channel incremental PID: one sequential datapath and one multiplier shared by NCH loops.
module pid_mc import pid_pkg::*; #(
  parameter int     DW       = 16,
  parameter int     GW       = 16,
  parameter int     NCH      = 4,
  parameter int     CW       = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int     SHIFT    = 11,
  parameter int     SP_RESET = 54321,
  parameter longint OUT_MIN  = 1,
  parameter longint OUT_MAX  = (longint'(1) << DW) - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [GW-1:0] cfg_kp,
  input  logic [GW-1:0] cfg_ki,
  input  logic [GW-1:0] cfg_kd,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_ch,
  input  logic [DW-1:0] cfg_sp,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_ch,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [CW-1:0] out_ch,
  output logic [DW-1:0] out_data,
  output logic          out_sat
);

  localparam int EW  = err_w(DW);
  localparam int DFW = diff_w(DW);
  localparam int PW  = prod_w(GW, DW);
  localparam int AW  = acc_w(GW, DW);
  localparam int UW  = AW + 1;

  state_t               state_q, state_d;
  logic [CW-1:0]        ch_q, ch_d;
  logic [DW-1:0]        data_q, data_d;
  logic [GW-1:0]        kp_q, kp_d, ki_q, ki_d, kd_q, kd_d;
  logic [DW-1:0]        sp_q, sp_d;
  logic signed [EW-1:0] ep_q, ep_d;
  logic [DW-1:0]        yp_q, yp_d;
  logic signed [EW-1:0] e_q, e_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic                 out_valid_q, out_valid_d;
  logic [CW-1:0]        out_ch_q, out_ch_d;
  logic [DW-1:0]        out_data_q, out_data_d;
  logic                 out_sat_q, out_sat_d;

  logic [CW-1:0]         rd_ch, sp_ch;
  logic [DW-1:0]         mem_sp, mem_yp;
  logic signed [EW-1:0]  mem_ep;
  logic                  hist_we, mem_clr;
  logic [GW-1:0]         mul_gain;
  logic signed [DFW-1:0] mul_opd;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  prod_ext, acc_shr;
  logic signed [UW-1:0]  u_val;
  logic signed [63:0]    u_ext, y_ext;

  // Out-of-range channel numbers fold back onto the implemented channels.
  assign rd_ch = CW'(32'(in_ch) % NCH);
  assign sp_ch = CW'(32'(cfg_ch) % NCH);

  assign in_ready  = (state_q == S_IDLE) && !clr;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  pid_chan_mem #(
    .DW(DW), .NCH(NCH), .CW(CW), .SP_RESET(SP_RESET)
  ) u_mem (
    .clk(clk), .rst_n(rst_n), .clr(mem_clr),
    .rd_ch(rd_ch), .rd_sp(mem_sp), .rd_ep(mem_ep), .rd_yp(mem_yp),
    .hist_we(hist_we), .hist_ch(ch_q), .hist_ep(e_q), .hist_yp(y_ext[DW-1:0]),
    .sp_we(cfg_we), .sp_ch(sp_ch), .sp_data(cfg_sp)
  );

  // Select the single multiplier's operands for the current PID term.
  always_comb begin
    mul_gain = '0;
    mul_opd  = '0;
    case (state_q)
      S_MP: begin
        mul_gain = kp_q;
        mul_opd  = {e_q[EW-1], e_q};
      end
      S_MI: begin
        mul_gain = ki_q;
        mul_opd  = {e_q[EW-1], e_q} + {ep_q[EW-1], ep_q};
      end
      S_MD: begin
        mul_gain = kd_q;
        mul_opd  = {e_q[EW-1], e_q} - {ep_q[EW-1], ep_q};
      end
      default: ;
    endcase
  end

  assign prod     = $signed({1'b0, mul_gain}) * mul_opd;
  assign prod_ext = {prod[PW-1], prod};

  // Output stage: incremental update of the previous output, floor-scaled, then saturated.
  assign acc_shr = acc_q >>> SHIFT;
  assign u_val   = $signed({{(UW-DW){1'b0}}, yp_q}) + $signed({acc_shr[AW-1], acc_shr});
  assign u_ext   = {{(64-UW){u_val[UW-1]}}, u_val};
  assign y_ext   = clamp_s64(u_ext, OUT_MIN, OUT_MAX);

  // Sequencer: accept, error, three multiply-accumulate steps, clamp and write-back.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    data_d      = data_q;
    kp_d        = kp_q;
    ki_d        = ki_q;
    kd_d        = kd_q;
    sp_d        = sp_q;
    ep_d        = ep_q;
    yp_d        = yp_q;
    e_d         = e_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    hist_we     = 1'b0;
    mem_clr     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clr) begin
          mem_clr = 1'b1;
        end else if (in_valid) begin
          ch_d    = rd_ch;
          data_d  = in_data;
          kp_d    = cfg_kp;
          ki_d    = cfg_ki;
          kd_d    = cfg_kd;
          sp_d    = mem_sp;
          ep_d    = mem_ep;
          yp_d    = mem_yp;
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        e_d     = $signed({1'b0, sp_q}) - $signed({1'b0, data_q});
        state_d = S_MP;
      end
      S_MP: begin
        acc_d   = prod_ext;
        state_d = S_MI;
      end
      S_MI: begin
        acc_d   = acc_q + prod_ext;
        state_d = S_MD;
      end
      S_MD: begin
        acc_d   = acc_q + prod_ext;
        state_d = S_CLAMP;
      end
      S_CLAMP: begin
        hist_we     = 1'b1;
        out_valid_d = 1'b1;
        out_ch_d    = ch_q;
        out_data_d  = y_ext[DW-1:0];
        out_sat_d   = (y_ext != u_ext);
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All controller registers; reset abandons any computation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      data_q      <= '0;
      kp_q        <= '0;
      ki_q        <= '0;
      kd_q        <= '0;
      sp_q        <= '0;
      ep_q        <= '0;
      yp_q        <= '0;
      e_q         <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      data_q      <= data_d;
      kp_q        <= kp_d;
      ki_q        <= ki_d;
      kd_q        <= kd_d;
      sp_q        <= sp_d;
      ep_q        <= ep_d;
      yp_q        <= yp_d;
      e_q         <= e_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_pid_mc.sv
// Directed bench for pid_mc: hand-computed results for the default 4-channel configuration.
module tb_pid_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg_kp = 16'd10, cfg_ki = 16'd1, cfg_kd = 16'd30;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = 2'd0;
  logic [15:0] cfg_sp = 16'd0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_ch = 2'd0;
  logic [15:0] in_data = 16'd0;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic [15:0] out_data;
  logic        out_sat;

  int n_checks = 0;
  int n_pass = 0;

  pid_mc dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_kp(cfg_kp), .cfg_ki(cfg_ki), .cfg_kd(cfg_kd),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sp(cfg_sp),
    .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  // One comparison: count it, and report observed vs expected on a miss.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Transfer one sample (optionally with a same-cycle setpoint write) and time the result.
  task automatic applyStimulus(input logic [1:0] ch, input logic [15:0] data,
                               input logic we, input logic [15:0] sp, output int lat);
    int guard;
    logic [15:0] kp_s, ki_s, kd_s;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b1; in_ch = ch; in_data = data;
    cfg_we = we; cfg_ch = ch; cfg_sp = sp;
    @(posedge clk);
    #1;
    kp_s = cfg_kp; ki_s = cfg_ki; kd_s = cfg_kd;
    in_valid = 1'b0; cfg_we = 1'b0;
    in_data = 16'hBEEF; in_ch = ch + 2'd1;
    cfg_kp = kp_s ^ 16'h5A5A; cfg_ki = ki_s ^ 16'h0F0F; cfg_kd = kd_s ^ 16'h3333;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    cfg_kp = kp_s; cfg_ki = ki_s; cfg_kd = kd_s;
  endtask

  // Full sample case: latency, result fields, one-cycle pulse and held data.
  task automatic runCase(input string tag, input logic [1:0] ch, input logic [15:0] data,
                         input logic we, input logic [15:0] sp,
                         input logic [15:0] exp_data, input logic exp_sat);
    int lat;
    applyStimulus(ch, data, we, sp, lat);
    checkOutput({tag, "_latency"}, lat, 5);
    checkOutput({tag, "_data"}, out_data, exp_data);
    checkOutput({tag, "_sat"}, out_sat, exp_sat);
    checkOutput({tag, "_ch"}, out_ch, ch);
    @(posedge clk);
    #1;
    checkOutput({tag, "_pulse_end"}, out_valid, 0);
    checkOutput({tag, "_held"}, out_data, exp_data);
  endtask

  // One-cycle history clear while idle.
  task automatic pulseClear();
    @(negedge clk);
    clr = 1'b1;
    #1;
    checkOutput("clr_blocks_ready", in_ready, 0);
    @(negedge clk);
    clr = 1'b0;
  endtask

  // Bound the whole run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Directed sequence.
  initial begin
    int xfers, pulses, last;
    logic gap_ok, saw_pulse;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_ch", out_ch, 0);
    checkOutput("rst_out_sat", out_sat, 0);
    checkOutput("rst_in_ready", in_ready, 1);

    // e = 0 gives u = 0, clamped up to OUT_MIN.
    runCase("zero_err", 2'd0, 16'd54321, 1'b0, 16'd0, 16'd1, 1'b1);

    // Fresh history: acc = 41*54321 = 2227161, >>>11 = 1087.
    pulseClear();
    runCase("ch0_first", 2'd0, 16'd0, 1'b0, 16'd0, 16'd1087, 1'b0);
    // acc = 543210 + 108642 = 651852, >>>11 = 318, 1087 + 318.
    runCase("ch0_second", 2'd0, 16'd0, 1'b0, 16'd0, 16'd1405, 1'b0);
    runCase("ch1_isolated", 2'd1, 16'd0, 1'b0, 16'd0, 16'd1087, 1'b0);
    pulseClear();
    runCase("ch0_after_clr", 2'd0, 16'd0, 1'b0, 16'd0, 16'd1087, 1'b0);

    // Setpoint 0 on ch2: acc = -41000, floor shift -21, clamp to 1.
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_sp = 16'd0;
    @(negedge clk);
    cfg_we = 1'b0;
    runCase("ch2_negative", 2'd2, 16'd1000, 1'b0, 16'd0, 16'd1, 1'b1);

    // Huge kp saturates at the top.
    cfg_kp = 16'd65535;
    runCase("ch3_kp_max", 2'd3, 16'd0, 1'b0, 16'd0, 16'd65535, 1'b1);
    cfg_kp = 16'd10;

    // Setpoint write in the accept cycle is not seen by that sample.
    runCase("ch1_sp_same_cycle", 2'd1, 16'd0, 1'b1, 16'd0, 16'd1087, 1'b0);
    // Now sp=0: acc = 54321 - 30*54321 = -1575309, >>>11 = -770, 1087 - 770.
    runCase("ch1_sp_applied", 2'd1, 16'd0, 1'b0, 16'd0, 16'd317, 1'b0);

    // in_valid held high: one transfer every 6 cycles.
    @(negedge clk);
    in_valid = 1'b1; in_ch = 2'd0; in_data = 16'd0;
    xfers = 0; pulses = 0; last = -1; gap_ok = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (in_ready) begin
        if (last >= 0 && c - last != 6) gap_ok = 1'b0;
        last = c;
        xfers++;
      end
      if (out_valid) pulses++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("tp_last_pulse", out_valid, 1);
    checkOutput("tp_transfers", xfers, 4);
    checkOutput("tp_pulses", pulses, 3);
    checkOutput("tp_gap", gap_ok, 1);

    // Reset while in MI abandons the sample and clears everything.
    @(negedge clk);
    in_valid = 1'b1; in_ch = 2'd0; in_data = 16'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_data", out_data, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw_pulse = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid) saw_pulse = 1'b1;
    end
    checkOutput("midrst_no_pulse", saw_pulse, 0);
    checkOutput("midrst_data_zero", out_data, 0);
    checkOutput("midrst_ch_zero", out_ch, 0);
    checkOutput("midrst_sat_zero", out_sat, 0);
    checkOutput("midrst_ready", in_ready, 1);
    runCase("ch0_after_rst", 2'd0, 16'd0, 1'b0, 16'd0, 16'd1087, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pid_mc.md
# pid_mc

Multi-channel, parametrised incremental PID controller. NCH independent control loops share one sequential datapath with a single multiplier; per-channel history and setpoints are held in a small channel memory. Runtime gains and setpoints, signed error arithmetic and a valid/ready sample interface let it sit between a sensor sampler and an actuator/PWM stage.

## Interface
- DW, 16: sample, setpoint and output width (unsigned)
- GW, 16: gain width (unsigned)
- NCH, 4: channel count (≥1); CW = max(1, clog2(NCH))
- SHIFT, 11: output scaling, arithmetic right shift (÷2048)
- SP_RESET, 54321: reset value of every channel setpoint
- OUT_MIN, 1 / OUT_MAX, 2**DW-1: output clamp bounds
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cfg_kp, cfg_ki, cfg_kd  in  GW each  gains, latched at sample accept
- cfg_we  in  1  setpoint write strobe
- cfg_ch  in  CW  setpoint write channel
- cfg_sp  in  DW  setpoint write data
- clr  in  1  clear all channel histories
- in_valid  in  1 / in_ready  out  1  sample handshake
- in_ch  in  CW / in_data  in  DW  sample channel and value
- out_valid  out  1  one-cycle result pulse
- out_ch  out  CW / out_data  out  DW  result channel and value (held until next result)
- out_sat  out  1  result was clamped

## Operation
- States: IDLE, ERR, MP, MI, MD, CLAMP.
- IDLE: in_ready=1 unless clr=1. Transfer on in_valid&in_ready: latch in_ch, in_data, gains; read channel's setpoint, e_prev, y_prev; → ERR. clr in IDLE zeroes all e_prev/y_prev, stays IDLE; clr outside IDLE ignored.
- ERR: e = setpoint − in_data, signed DW+1 bits. → MP.
- MP: acc = kp·e. MI: acc += ki·(e+e_prev). MD: acc += kd·(e−e_prev). Differences signed DW+2; gains zero-extended; acc signed GW+DW+4, no overflow possible.
- CLAMP: u = y_prev + (acc >>> SHIFT) (floor). y = clamp(u, OUT_MIN, OUT_MAX); out_sat = (y≠u). Write e_prev←e, y_prev←y (clamped) for the channel. Register out_data=y, out_ch, out_sat, out_valid=1. → IDLE.
- cfg_we accepted any cycle, any state. Setpoint read at accept; a write to the same channel in the accept cycle is not seen by that sample.
- in_ch ≥ NCH: sample accepted, processed as channel in_ch mod NCH.
- Reset (any time, incl. mid-computation): state IDLE, out_valid=0, out_data=0, out_ch=0, out_sat=0, all e_prev=0, y_prev=0, setpoints=SP_RESET; in_ready=1 after release.

## Timing
- Transfer at edge T → out_valid high in the cycle after edge T+5 (latency 5), for exactly one cycle.
- in_ready=0 from T until state returns to IDLE (edge T+5); earliest next transfer is edge T+6. Throughput 1 sample / 6 cycles.
- out_valid has no ready; downstream must accept it.
- in_data/in_ch need only be stable in the transfer cycle.

## Structure
- Package pid_pkg: state enum, width helpers (error, product, acc widths), clamp function.
- Sub-module pid_chan_mem: NCH-entry register array for {setpoint, e_prev, y_prev}, one combinational read port, one history write port, one setpoint write port, global clear, async reset.
- One multiplier instance, operand-muxed by state.

## Test plan
Defaults, gains kp=10, ki=1, kd=30 unless stated.
- After reset, ch0 in_data=54321 → e=0, out_data=1 (clamped from 0), out_sat=1, out_valid 5 cycles after transfer.
- Fresh ch0 in_data=0 → acc=2227161, out_data=1087, out_sat=0; repeat ch0 in_data=0 → acc=651852, out_data=1405.
- After ch0 run, ch1 in_data=0 → out_data=1087, out_ch=1 (channel isolation); then clr, ch0 in_data=0 → 1087 again.
- cfg_we ch2 sp=0, ch2 in_data=1000 → acc=−41000, shift −21, out_data=1, out_sat=1.
- kp=65535, fresh ch3 in_data=0 → out_data=65535, out_sat=1.
- in_valid held high while busy → exactly one transfer per 6 cycles; rst_n low at MI → out_valid never pulses, out_data=0, next ch0 in_data=0 → 1087.
